reaction_capture: RTL and testbench
===================================

Name: reaction_capture

Overview:
- Input-side counterpart to the LED driver in the reaction timer: the LED driver shows the stimulus, this block captures the player's button response.
- Synchronises and debounces the raw push-button, then measures elapsed milliseconds from test-LED-on to press.
- Flags early presses (false start) and no-response (timeout); hands a saturating ms result to the display/score logic.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency; TICK_DIV = CLK_FREQ_HZ/1000 cycles per ms.
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised button must be stable before the debounced level changes (10 ms at 100 MHz).
- MAX_MS, 9999, timeout/saturation value; must be < 2^14.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst_n  in  1  synchronous, active-low reset.
- btn_raw  in  1  asynchronous, bouncy push-button, active high.
- arm  in  1  one-cycle pulse: waiting period begins, presses from now count as false starts.
- led_on  in  1  level: test LED lit (stimulus shown).
- busy  out  1  high in ARMED or TIMING.
- btn_level  out  1  debounced button level.
- result_ms  out  14  last measured reaction time in ms; held until next arm.
- result_valid  out  1  one-cycle pulse when result_ms is updated by a press.
- false_start  out  1  one-cycle pulse on early press.
- timeout  out  1  one-cycle pulse when MAX_MS is reached with no press.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; sync flops, debounce counter, btn_level, prescaler, ms counter, result_ms are 0; all pulses 0. Reset mid-measurement aborts with no pulse.
- Button path: 2-FF synchroniser, then debounce counter. btn_level toggles only after DEBOUNCE_CYCLES consecutive cycles where the synchronised value differs from btn_level; any agreeing cycle clears the counter. A press event is a one-cycle pulse on the btn_level 0->1 edge. Raw-to-event latency is 2 + DEBOUNCE_CYCLES cycles, constant and not compensated in result_ms.
- IDLE:
  - arm -> ARMED.
  - Presses are ignored.
- ARMED:
  - press event -> false_start pulse, go to IDLE.
  - If btn_level is already 1 on entry (button held at arm), assert false_start in the first ARMED cycle and go to IDLE.
  - led_on==1 with no press -> TIMING; prescaler and ms counter cleared.
  - Press and led_on in the same cycle -> false start (press has priority).
- TIMING:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and the ms counter increments.
  - A press event in TIMING cycle N (entry cycle N=0) loads result_ms = floor(N/TICK_DIV) from the registered counter, pulses result_valid, and moves to DONE.
  - When the ms counter would reach MAX_MS: result_ms = MAX_MS, timeout pulse, go to IDLE, no result_valid.
  - Press on the same cycle as the timeout tick -> treated as a press; result_ms = MAX_MS-1 (registered value) with result_valid.
  - led_on dropping during TIMING is ignored.
  - arm during TIMING is ignored.
- DONE:
  - result_ms held.
  - arm -> ARMED.
  - Presses are ignored.
- result_ms changes only on result_valid or timeout. Outputs are registered; pulses assert the cycle after the triggering event.

Decomposition:
- Package reaction_pkg: state enum {IDLE, ARMED, TIMING, DONE}, MS_W=14, default MAX_MS, function computing TICK_DIV.
- Sub-module button_debouncer (synchroniser + debounce counter + rising-edge pulse; outputs level and press pulse), reusable for the start button.

Test Plan (CLK_FREQ_HZ=10_000 so TICK_DIV=10, DEBOUNCE_CYCLES=4, MAX_MS=50):
- Reset: rst_n low 3 cycles with btn_raw=1 -> all outputs 0, busy=0. After release with btn_raw held, btn_level rises exactly 6 cycles later.
- Normal: arm, led_on=1 after 20 cycles, press aligned so the event lands at TIMING cycle 253 -> result_valid one cycle, result_ms=25, busy drops, result held through 100 idle cycles.
- Bounce: btn_raw toggles every 2 cycles for 20 cycles then settles high -> exactly one press event, one result_valid.
- False start: arm, press before led_on -> single false_start pulse, no result_valid, state IDLE. Repeat with button held during arm -> false_start in first ARMED cycle.
- Timeout: arm, led_on, no press -> timeout pulse at TIMING cycle 500, result_ms=50. A later press produces no pulse.
- Reset mid-TIMING at cycle 120: no pulses; result_ms=0 and busy=0 after reset.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer capture path.
//   state_e    : capture FSM states
//   MS_W       : width of the millisecond result
//   tick_div() : clock cycles per millisecond for a given clock frequency
//   cnt_w()    : counter width able to hold 0..n-1 (never less than 1 bit)
package reaction_pkg;

    localparam int unsigned MS_W           = 14;
    localparam int unsigned DEFAULT_MAX_MS = 9999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_TIMING = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int unsigned tick_div(input int unsigned clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reaction_capture_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter, rising-edge pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   btn_raw_i   : asynchronous bouncy button, active high
//   level_o     : debounced level
//   press_o     : one-cycle pulse, coincident with level_o going 0->1
module button_debouncer
    import reaction_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned       CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/reaction_capture.sv
// Reaction capture: measures ms from test-LED-on to debounced button press,
// flagging false starts and timeouts.
//   clk, rst_n    : clock, synchronous active-low reset
//   btn_raw       : asynchronous bouncy button, active high
//   arm           : one-cycle pulse starting the waiting period
//   led_on        : test LED lit
//   busy          : high while ARMED or TIMING
//   btn_level     : debounced button level
//   result_ms     : last reaction time / MAX_MS on timeout, held otherwise
//   result_valid  : pulse when a press updates result_ms
//   false_start   : pulse on a press before the LED
//   timeout       : pulse when MAX_MS elapses with no press
module reaction_capture
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_MS          = DEFAULT_MAX_MS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_raw,
    input  logic            arm,
    input  logic            led_on,
    output logic            busy,
    output logic            btn_level,
    output logic [MS_W-1:0] result_ms,
    output logic            result_valid,
    output logic            false_start,
    output logic            timeout
);

    localparam int unsigned        TICK_DIV   = tick_div(CLK_FREQ_HZ);
    localparam int unsigned        PRESC_W    = cnt_w(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]    MS_MAX     = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(MAX_MS - 1);

    logic level, press;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [MS_W-1:0]    result_q, result_d;
    logic               valid_q, valid_d;
    logic               fs_q, fs_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw_i(btn_raw),
        .level_o  (level),
        .press_o  (press)
    );

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        ms_d     = ms_q;
        result_d = result_q;
        valid_d  = 1'b0;
        fs_d     = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A held button counts as a false start; press beats led_on.
                if (press || level) begin
                    fs_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (led_on) begin
                    presc_d = '0;
                    ms_d    = '0;
                    state_d = ST_TIMING;
                end
            end
            ST_TIMING: begin
                // Press wins over a coincident timeout tick and reports the registered count.
                if (press) begin
                    result_d = ms_q;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (ms_q == MS_LAST) begin
                        result_d = MS_MAX;
                        to_d     = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_DONE: begin
                if (arm) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ARMED) || (state_d == ST_TIMING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign btn_level    = level;
    assign result_ms    = result_q;
    assign result_valid = valid_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_reaction_capture.sv
// Scoreboard bench for reaction_capture (TICK_DIV=10, DEBOUNCE_CYCLES=4, MAX_MS=50).
// Stimulus pushes {pulse kind, result_ms, arrival cycle}; the monitor pops on every pulse.
module tb_reaction_capture;

    localparam logic [2:0] K_RES = 3'b100;
    localparam logic [2:0] K_FS  = 3'b010;
    localparam logic [2:0] K_TO  = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [13:0] ms;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, btn_raw, arm, led_on;
    logic        busy, btn_level, result_valid, false_start, timeout;
    logic [13:0] result_ms;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    reaction_capture #(
        .CLK_FREQ_HZ    (10_000),
        .DEBOUNCE_CYCLES(4),
        .MAX_MS         (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .arm         (arm),
        .led_on      (led_on),
        .busy        (busy),
        .btn_level   (btn_level),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .false_start (false_start),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic wait_level(input logic v, input int budget);
        int k;
        k = 0;
        while (btn_level !== v && k < budget) begin
            step(1);
            k++;
        end
        chk("btn_level_settle", 32'(btn_level), 32'(v));
    endtask

    task automatic push(input logic [2:0] kind, input logic [13:0] ms, input int c);
        exp_t e;
        e.kind = kind;
        e.ms   = ms;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Arm, then light the LED; returns the cycle index of TIMING cycle 0.
    task automatic arm_and_light(input int gap, output int t0);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        if (gap > 0) step(gap);
        led_on = 1'b1;
        t0 = cyc + 1;
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] k;
        exp_t       e;
        k = {result_valid, false_start, timeout};
        if (k != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(k), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("pulse_ms", 32'(result_ms), 32'(e.ms));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, r, c, k2;
        rst_n = 1'b0; btn_raw = 1'b1; arm = 1'b0; led_on = 1'b0;

        // Reset with button held high
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_result", 32'(result_ms), 0);
        chk("rst_pulses", 32'({result_valid, false_start, timeout}), 0);
        rst_n = 1'b1;
        c = cyc;
        wait_until(c + 5);
        chk("level_before_6", 32'(btn_level), 0);
        step(1);
        chk("level_at_6", 32'(btn_level), 1);
        btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Normal measurement: event at TIMING cycle 253 -> 25 ms
        arm_and_light(19, t0);
        wait_until(t0 + 247);
        btn_raw = 1'b1;
        push(K_RES, 14'd25, t0 + 254);
        chk("normal_busy", 32'(busy), 1);
        wait_until(t0 + 254);
        chk("normal_busy_drop", 32'(busy), 0);
        step(100);
        chk("normal_held", 32'(result_ms), 25);
        led_on = 1'b0; btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Bounce then settle high: one event at TIMING cycle 76 -> 7 ms
        arm_and_light(0, t0);
        wait_until(t0 + 50);
        r = cyc;
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            step(2);
        end
        btn_raw = 1'b1;
        push(K_RES, 14'd7, r + 27);
        wait_until(r + 35);
        chk("bounce_busy", 32'(busy), 0);
        chk("bounce_result", 32'(result_ms), 7);
        led_on = 1'b0; btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // False start: press before LED
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        btn_raw = 1'b1;
        r = cyc;
        push(K_FS, 14'd7, r + 7);
        wait_until(r + 9);
        chk("fs_busy", 32'(busy), 0);
        chk("fs_result", 32'(result_ms), 7);

        // Button already held at arm: false start in first ARMED cycle
        k2 = cyc;
        arm = 1'b1;
        push(K_FS, 14'd7, k2 + 2);
        step(1);
        arm = 1'b0;
        wait_until(k2 + 4);
        chk("held_busy", 32'(busy), 0);
        btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Press and LED in the same cycle: press wins
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        btn_raw = 1'b1;
        r = cyc;
        push(K_FS, 14'd7, r + 7);
        wait_until(r + 6);
        led_on = 1'b1;
        wait_until(r + 10);
        chk("prio_busy", 32'(busy), 0);
        led_on = 1'b0; btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Timeout; LED drop and re-arm during TIMING are ignored
        arm_and_light(0, t0);
        wait_until(t0 + 100);
        arm = 1'b1;
        step(1);
        arm = 1'b0; led_on = 1'b0;
        push(K_TO, 14'd50, t0 + 500);
        wait_until(t0 + 499);
        chk("to_busy_before", 32'(busy), 1);
        step(1);
        chk("to_busy_after", 32'(busy), 0);
        chk("to_result", 32'(result_ms), 50);
        btn_raw = 1'b1;
        step(20);
        chk("to_late_press_result", 32'(result_ms), 50);
        btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Press on the timeout tick (TIMING cycle 499): reported as 49 ms
        arm_and_light(0, t0);
        wait_until(t0 + 493);
        btn_raw = 1'b1;
        push(K_RES, 14'd49, t0 + 500);
        wait_until(t0 + 502);
        chk("edge_result", 32'(result_ms), 49);
        chk("edge_busy", 32'(busy), 0);
        led_on = 1'b0; btn_raw = 1'b0;
        wait_level(1'b0, 20);

        // Reset mid-TIMING at cycle 120
        arm_and_light(0, t0);
        wait_until(t0 + 120);
        rst_n = 1'b0;
        step(3);
        chk("midrst_result", 32'(result_ms), 0);
        chk("midrst_busy", 32'(busy), 0);
        rst_n = 1'b1; led_on = 1'b0;
        step(20);
        chk("midrst_idle_busy", 32'(busy), 0);

        step(10);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
